// File: rtl/irq_pkg.sv
// Shared constants and types for the interrupt controller.
package irq_pkg;

  // Width of the vector number presented to the core.
  localparam int VECT_W = 3;

  // Register offsets inside the 4-byte window.
  localparam logic [1:0] OFS_MASK = 2'd0;
  localparam logic [1:0] OFS_PEND = 2'd1;
  localparam logic [1:0] OFS_STAT = 2'd2;
  localparam logic [1:0] OFS_OVR  = 2'd3;

  // IDLE: free to issue. SERVICE: one interrupt outstanding, waiting for EOI.
  typedef enum logic {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } state_t;

endpackage

// File: rtl/irq_prio.sv
// Fixed-priority encoder: lowest set request index wins.
module irq_prio
  import irq_pkg::*;
#(
  parameter int NSRC = 8
) (
  input  logic [NSRC-1:0]   i_req,
  output logic              o_any,
  output logic [VECT_W-1:0] o_idx
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    o_any = |i_req;
    o_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx = VECT_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller feeding the core's toggle-style intr/vect.
// Events are latched as pending bits, masked, priority-encoded, and issued one
// at a time; the next issue waits for an EOI write or the service timeout.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int          NSRC = 8,
  parameter logic [15:0] BASE = 16'h0023,
  parameter int          TMO  = 65535
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [NSRC-1:0]   i_irq,
  input  logic [15:0]       i_address,
  input  logic [7:0]        i_wdata,
  input  logic              i_we,
  output logic [7:0]        o_rdata,
  output logic              o_hit,
  output logic              o_intr,
  output logic [VECT_W-1:0] o_vect
);

  // Timer is wide enough to hold TMO itself so it can park there.
  localparam int            TW       = $clog2(TMO + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);
  localparam logic [TW-1:0] TMO_SAT  = TW'(TMO);

  logic [NSRC-1:0]   r_irq_q;
  logic [NSRC-1:0]   r_pend;
  logic [NSRC-1:0]   r_mask;
  logic [NSRC-1:0]   r_ovr;
  logic              r_tmo;
  logic              r_intr;
  logic [VECT_W-1:0] r_vect;
  logic [TW-1:0]     r_timer;
  state_t            r_state;

  logic [15:0]       w_ofs;
  logic [1:0]        w_off;
  logic              w_hit;
  logic              w_wr_mask;
  logic              w_wr_pend;
  logic              w_wr_stat;
  logic              w_wr_ovr;
  logic [NSRC-1:0]   w_wsrc;
  logic [NSRC-1:0]   w_event;
  logic [NSRC-1:0]   w_eligible;
  logic              w_any;
  logic [VECT_W-1:0] w_idx;
  logic [NSRC-1:0]   w_pend_clr;
  logic [NSRC-1:0]   w_ovr_clr;
  logic [NSRC-1:0]   w_issue_oh;
  logic [NSRC-1:0]   w_pend_next;
  logic [NSRC-1:0]   w_ovr_next;
  logic              w_tmo_next;
  state_t            w_state_next;
  logic              w_intr_next;
  logic [VECT_W-1:0] w_vect_next;
  logic [TW-1:0]     w_timer_next;
  logic              w_issue;
  logic              w_tmo_set;

  // Address decode: subtracting BASE keeps the window check a single compare.
  assign w_ofs     = i_address - BASE;
  assign w_off     = w_ofs[1:0];
  assign w_hit     = (w_ofs < 16'd4);
  assign w_wr_mask = i_we & w_hit & (w_off == OFS_MASK);
  assign w_wr_pend = i_we & w_hit & (w_off == OFS_PEND);
  assign w_wr_stat = i_we & w_hit & (w_off == OFS_STAT);
  assign w_wr_ovr  = i_we & w_hit & (w_off == OFS_OVR);
  assign w_wsrc    = i_wdata[NSRC-1:0];

  assign w_event    = i_irq & ~r_irq_q;
  assign w_eligible = r_pend & r_mask;
  assign w_pend_clr = w_wr_pend ? w_wsrc : '0;
  assign w_ovr_clr  = w_wr_ovr ? w_wsrc : '0;
  assign w_issue_oh = w_issue ? (NSRC'(1) << w_idx) : '0;

  irq_prio #(
    .NSRC (NSRC)
  ) u_prio (
    .i_req (w_eligible),
    .o_any (w_any),
    .o_idx (w_idx)
  );

  // Per-source update: a new event always beats a clear in the same cycle.
  for (genvar gi = 0; gi < NSRC; gi++) begin : g_bit
    assign w_pend_next[gi] = w_event[gi] |
                             (r_pend[gi] & ~w_pend_clr[gi] & ~w_issue_oh[gi]);
    assign w_ovr_next[gi]  = (w_event[gi] & r_pend[gi]) |
                             (r_ovr[gi] & ~w_ovr_clr[gi]);
  end

  // Timeout setting the flag beats a software clear landing on the same edge.
  assign w_tmo_next = w_tmo_set | (r_tmo & ~(w_wr_ovr & i_wdata[7]));

  // Next-state logic: issue from IDLE, leave SERVICE on EOI or timeout.
  always_comb begin
    w_state_next = r_state;
    w_intr_next  = r_intr;
    w_vect_next  = r_vect;
    w_timer_next = r_timer;
    w_issue      = 1'b0;
    w_tmo_set    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_issue      = 1'b1;
          w_intr_next  = ~r_intr;
          w_vect_next  = w_idx;
          w_timer_next = '0;
          w_state_next = SERVICE;
        end
      end
      SERVICE: begin
        if (w_wr_stat) begin
          w_state_next = IDLE;
        end else if (r_timer == TMO_LAST) begin
          w_tmo_set    = 1'b1;
          w_timer_next = TMO_SAT;
          w_state_next = IDLE;
        end else begin
          w_timer_next = r_timer + TW'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // FSM and issue registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_intr  <= 1'b0;
      r_vect  <= '0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_next;
      r_intr  <= w_intr_next;
      r_vect  <= w_vect_next;
      r_timer <= w_timer_next;
    end
  end

  // Software-visible registers and the edge-detect history.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_irq_q <= '0;
      r_pend  <= '0;
      r_mask  <= '0;
      r_ovr   <= '0;
      r_tmo   <= 1'b0;
    end else begin
      r_irq_q <= i_irq;
      r_pend  <= w_pend_next;
      r_ovr   <= w_ovr_next;
      r_tmo   <= w_tmo_next;
      if (w_wr_mask) begin
        r_mask <= w_wsrc;
      end
    end
  end

  // Read mux: combinational from the address, zero outside the window.
  always_comb begin
    o_rdata = 8'h00;
    if (w_hit) begin
      case (w_off)
        OFS_MASK: o_rdata = 8'(r_mask);
        OFS_PEND: o_rdata = 8'(r_pend);
        OFS_STAT: o_rdata = {(r_state == SERVICE), r_tmo, 3'b000, r_vect};
        OFS_OVR:  o_rdata = 8'(r_ovr);
        default:  o_rdata = 8'h00;
      endcase
    end
  end

  assign o_hit  = w_hit;
  assign o_intr = r_intr;
  assign o_vect = r_vect;

endmodule
